// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: coin credit, item vend authorisation, auto-return timer and greedy change dispense.
// Define VEND_AUDIT_EN to add the o_sales_total running sales counter.
module vend_txn_controller #(
  parameter int NUM_COINS   = 3,
  parameter int NUM_ITEMS   = 4,
  parameter int ITEM_PRICE0 = 400,
  parameter int ITEM_PRICE1 = 500,
  parameter int ITEM_PRICE2 = 1000,
  parameter int ITEM_PRICE3 = 2000,
  parameter int WAIT_CYCLES = 100,
  parameter int BAL_W       = 16,
  parameter int MAX_BALANCE = 10000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_COINS-1:0] i_input_coin,
  input  logic [NUM_ITEMS-1:0] i_select_item,
  input  logic                 i_trigger_return,
  input  logic                 i_return_ready,
  output logic                 o_return_valid,
  output logic [NUM_COINS-1:0] o_return_coin,
  output logic [NUM_ITEMS-1:0] o_output_item,
  output logic [NUM_ITEMS-1:0] o_available_item,
  output logic                 o_coin_reject,
  output logic [BAL_W-1:0]     o_balance,
  output logic [31:0]          o_wait_time,
  output logic                 o_busy
`ifdef VEND_AUDIT_EN
  ,
  output logic [31:0]          o_sales_total
`endif
);

  typedef enum logic [1:0] {IDLE, CREDIT, RETURN} state_e;

  state_e               state_q, state_d;
  logic [BAL_W-1:0]     balance_q, balance_d;
  logic [31:0]          wait_q, wait_d;
  logic                 valid_q, valid_d;
  logic                 reject_q, reject_d;
  logic [NUM_ITEMS-1:0] item_q, item_d;

  logic                 coinOneHot, coinAccept, coinReject, selValid, leaveCredit;
  logic [BAL_W:0]       coinSum;
  logic [BAL_W-1:0]     coinVal, selPrice, retVal;
  logic [NUM_COINS-1:0] retCoin;

  function automatic logic [BAL_W-1:0] coinValue(input logic [NUM_COINS-1:0] coin);
    logic [BAL_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (coin[i]) begin
        case (i)
          0:       v = BAL_W'(100);
          1:       v = BAL_W'(500);
          default: v = BAL_W'(1000);
        endcase
      end
    end
    return v;
  endfunction

  function automatic logic [BAL_W-1:0] itemPrice(input logic [NUM_ITEMS-1:0] item);
    logic [BAL_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (item[i]) begin
        case (i)
          0:       p = BAL_W'(ITEM_PRICE0);
          1:       p = BAL_W'(ITEM_PRICE1);
          2:       p = BAL_W'(ITEM_PRICE2);
          default: p = BAL_W'(ITEM_PRICE3);
        endcase
      end
    end
    return p;
  endfunction

  always_comb begin
    coinOneHot  = $onehot(i_input_coin) && (state_q != RETURN);
    coinVal     = coinValue(i_input_coin);
    coinSum     = {1'b0, balance_q} + {1'b0, coinVal};
    coinAccept  = coinOneHot && (coinSum <= (BAL_W+1)'(MAX_BALANCE));
    coinReject  = coinOneHot && !(coinSum <= (BAL_W+1)'(MAX_BALANCE));
    // A pending timeout behaves like a return request: coins still count, selects are dropped.
    leaveCredit = i_trigger_return || (wait_q == 32'd0);
    selPrice    = itemPrice(i_select_item);
    selValid    = (state_q == CREDIT) && !leaveCredit && $onehot(i_select_item) &&
                  (selPrice <= balance_q);
    if (balance_q >= BAL_W'(1000))     retCoin = NUM_COINS'(3'b100);
    else if (balance_q >= BAL_W'(500)) retCoin = NUM_COINS'(3'b010);
    else                               retCoin = NUM_COINS'(3'b001);
    retVal = coinValue(retCoin);
  end

  always_comb begin
    state_d   = state_q;
    balance_d = balance_q;
    wait_d    = wait_q;
    valid_d   = 1'b0;
    reject_d  = coinReject;
    item_d    = '0;
    case (state_q)
      IDLE: begin
        wait_d = 32'(WAIT_CYCLES);
        if (coinAccept) begin
          balance_d = coinSum[BAL_W-1:0];
          state_d   = CREDIT;
        end
      end
      CREDIT: begin
        balance_d = balance_q + (coinAccept ? coinVal : '0) - (selValid ? selPrice : '0);
        item_d    = selValid ? i_select_item : '0;
        if (leaveCredit) begin
          state_d = RETURN;
          wait_d  = 32'(WAIT_CYCLES);
        end else if (coinAccept || selValid) begin
          wait_d = 32'(WAIT_CYCLES);
        end else begin
          wait_d = wait_q - 32'd1;
        end
      end
      RETURN: begin
        wait_d = 32'(WAIT_CYCLES);
        // After each accepted coin valid drops for a cycle so the next coin sees the updated balance.
        if (valid_q) begin
          if (i_return_ready) begin
            balance_d = balance_q - retVal;
            if (balance_q == retVal) state_d = IDLE;
          end else begin
            valid_d = 1'b1;
          end
        end else if (balance_q == '0) begin
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      balance_q <= '0;
      wait_q    <= 32'(WAIT_CYCLES);
      valid_q   <= 1'b0;
      reject_q  <= 1'b0;
      item_q    <= '0;
    end else begin
      state_q   <= state_d;
      balance_q <= balance_d;
      wait_q    <= wait_d;
      valid_q   <= valid_d;
      reject_q  <= reject_d;
      item_q    <= item_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      o_available_item[i] = (state_q == CREDIT) &&
                            (itemPrice(NUM_ITEMS'(1) << i) <= balance_q);
    end
  end

  assign o_return_valid = valid_q;
  assign o_return_coin  = valid_q ? retCoin : '0;
  assign o_output_item  = item_q;
  assign o_coin_reject  = reject_q;
  assign o_balance      = balance_q;
  assign o_wait_time    = wait_q;
  assign o_busy         = (state_q == RETURN);

`ifdef VEND_AUDIT_EN
  logic [31:0] sales_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sales_q <= '0;
    else       sales_q <= sales_q + 32'(itemPrice(item_q));
  end

  assign o_sales_total = sales_q;
`endif

endmodule

// File: tb/tb_vend_txn_controller.sv
// Randomized scoreboard bench for vend_txn_controller against a transaction-level credit model.
// Define VEND_AUDIT_EN to also check o_sales_total.
module tb_vend_txn_controller;

  localparam int W    = 100;
  localparam int MAXB = 10000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  i_input_coin = '0;
  logic [3:0]  i_select_item = '0;
  logic        i_trigger_return = 1'b0;
  logic        i_return_ready = 1'b0;
  logic        o_return_valid;
  logic [2:0]  o_return_coin;
  logic [3:0]  o_output_item;
  logic [3:0]  o_available_item;
  logic        o_coin_reject;
  logic [15:0] o_balance;
  logic [31:0] o_wait_time;
  logic        o_busy;
`ifdef VEND_AUDIT_EN
  logic [31:0] o_sales_total;
`endif

  vend_txn_controller dut (
    .clk              (clk),
    .reset            (reset),
    .i_input_coin     (i_input_coin),
    .i_select_item    (i_select_item),
    .i_trigger_return (i_trigger_return),
    .i_return_ready   (i_return_ready),
    .o_return_valid   (o_return_valid),
    .o_return_coin    (o_return_coin),
    .o_output_item    (o_output_item),
    .o_available_item (o_available_item),
    .o_coin_reject    (o_coin_reject),
    .o_balance        (o_balance),
    .o_wait_time      (o_wait_time),
`ifdef VEND_AUDIT_EN
    .o_sales_total    (o_sales_total),
`endif
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_CREDIT, M_RET} mstate_e;

  int          checks = 0;
  int          failures = 0;
  int          coinQ[$];
  logic [3:0]  vendQ[$];
  int          rejectQ[$];
  mstate_e     mState = M_IDLE;
  int          mBal = 0;
  int          mTimer = W;
  int          retCycles = 0;
  int          readyMode = 0;
  logic [31:0] mSales = '0;
  logic [31:0] pend1 = '0;
  logic [31:0] pend2 = '0;

  function automatic int coinValue(input logic [2:0] c);
    case (c)
      3'b001:  return 100;
      3'b010:  return 500;
      3'b100:  return 1000;
      default: return 0;
    endcase
  endfunction

  function automatic int itemPrice(input logic [3:0] s);
    case (s)
      4'b0001: return 400;
      4'b0010: return 500;
      4'b0100: return 1000;
      4'b1000: return 2000;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] expAvail();
    logic [3:0] a;
    a = '0;
    for (int i = 0; i < 4; i++)
      a[i] = (mState == M_CREDIT) && (itemPrice(4'(1 << i)) <= mBal);
    return a;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic finishRun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic pushChange(input int b);
    int c;
    while (b > 0) begin
      c = (b >= 1000) ? 1000 : (b >= 500) ? 500 : 100;
      coinQ.push_back(c);
      b -= c;
    end
  endtask

  // Compare registered outputs against the model one step after each clock edge.
  task automatic compareCycle();
    mSales += pend2;
    pend2 = pend1;
    pend1 = '0;
    if (mState == M_RET) begin
      if (o_busy) begin
        retCycles++;
        checkOutput("wait_in_return", o_wait_time, W);
        if (retCycles > 300) begin
          checks++;
          failures++;
          $display("[TB] FAIL return_timeout actual=%0d cycles required<=300", retCycles);
          finishRun();
        end
      end else begin
        mState = M_IDLE;
        mBal   = 0;
        mTimer = W;
        checkOutput("coins_left", coinQ.size(), 0);
      end
    end
    if (mState != M_RET) begin
      checkOutput("balance", o_balance, mBal);
      checkOutput("available", o_available_item, expAvail());
      checkOutput("wait_time", o_wait_time, mTimer);
      checkOutput("busy", o_busy, 0);
    end
`ifdef VEND_AUDIT_EN
    checkOutput("sales_total", o_sales_total, mSales);
`endif
  endtask

  // Drive one cycle of inputs, advance the model by the same transaction, then compare.
  task automatic applyStimulus(input logic [2:0] c, input logic [3:0] s, input logic t);
    int  v, p, newBal;
    bit  retNow, touched;
    i_input_coin     = c;
    i_select_item    = s;
    i_trigger_return = t;
    i_return_ready   = (readyMode == 1) ? 1'b1 :
                       (readyMode == 2) ? 1'b0 : ($urandom_range(0, 9) < 6);
    v = coinValue(c);
    p = itemPrice(s);
    if (mState == M_IDLE) begin
      if (v != 0) begin
        if (mBal + v > MAXB) rejectQ.push_back(1);
        else begin
          mBal   = mBal + v;
          mState = M_CREDIT;
          mTimer = W;
        end
      end
    end else if (mState == M_CREDIT) begin
      retNow  = t || (mTimer == 0);
      touched = 0;
      newBal  = mBal;
      if (v != 0) begin
        if (mBal + v > MAXB) rejectQ.push_back(1);
        else begin
          newBal += v;
          touched = 1;
        end
      end
      if (!retNow && p != 0 && p <= mBal) begin
        newBal -= p;
        vendQ.push_back(s);
        pend1   = 32'(p);
        touched = 1;
      end
      mBal = newBal;
      if (retNow) begin
        pushChange(mBal);
        mState    = M_RET;
        mTimer    = W;
        retCycles = 0;
      end else begin
        mTimer = touched ? W : mTimer - 1;
      end
    end
    @(posedge clk);
    #1;
    compareCycle();
  endtask

  task automatic doReset();
    reset            = 1'b1;
    i_input_coin     = '0;
    i_select_item    = '0;
    i_trigger_return = 1'b0;
    i_return_ready   = 1'b0;
    coinQ.delete();
    vendQ.delete();
    rejectQ.delete();
    mState = M_IDLE;
    mBal   = 0;
    mTimer = W;
    mSales = '0;
    pend1  = '0;
    pend2  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    compareCycle();
  endtask

  task automatic drainReturn();
    for (int n = 0; n < 400 && mState == M_RET; n++) applyStimulus('0, '0, 1'b0);
  endtask

  // Monitor pops expected vends, rejects and dispensed coins whenever the DUT presents them.
  always @(negedge clk) begin
    if (!reset) begin
      if (o_output_item != '0) begin
        if (vendQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL vend_unexpected actual=%b required=none", o_output_item);
        end else checkOutput("vend_item", o_output_item, vendQ.pop_front());
      end
      if (o_coin_reject) begin
        if (rejectQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL reject_unexpected actual=1 required=0");
        end else checkOutput("coin_reject", o_coin_reject, rejectQ.pop_front());
      end
      if (o_return_valid) begin
        if (coinQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL coin_unexpected actual=%b required=none", o_return_coin);
        end else begin
          checkOutput("return_coin", coinValue(o_return_coin), coinQ[0]);
          if (i_return_ready) void'(coinQ.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    checks++;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    finishRun();
  end

  initial begin
    logic [2:0] c;
    logic [3:0] s;
    int         r;

    #3;
    checkOutput("reset_valid", o_return_valid, 0);
    checkOutput("reset_item", o_output_item, 0);
    checkOutput("reset_reject", o_coin_reject, 0);
    checkOutput("reset_coin", o_return_coin, 0);
    doReset();

    $display("[TB] coins 500,500,100 then vend item1");
    applyStimulus(3'b010, '0, 1'b0);
    applyStimulus(3'b010, '0, 1'b0);
    applyStimulus(3'b001, '0, 1'b0);
    checkOutput("bal_1100", o_balance, 1100);
    checkOutput("avail_0111", o_available_item, 4'b0111);
    checkOutput("wait_full", o_wait_time, 100);
    applyStimulus('0, 4'b0010, 1'b0);
    checkOutput("bal_600", o_balance, 600);
    applyStimulus('0, 4'b0100, 1'b0);
    checkOutput("bal_after_ignored", o_balance, 600);

    $display("[TB] timeout and auto return");
    readyMode = 1;
    for (int n = 0; n < 150 && mState != M_RET; n++) applyStimulus('0, '0, 1'b0);
    checkOutput("timeout_entered_return", o_busy, 1);
    drainReturn();
    checkOutput("timeout_idle_bal", o_balance, 0);

    $display("[TB] user return with stalled hopper");
    applyStimulus(3'b100, '0, 1'b0);
    applyStimulus(3'b010, '0, 1'b0);
    applyStimulus(3'b001, '0, 1'b0);
    readyMode = 2;
    applyStimulus('0, 4'b0001, 1'b1);
    repeat (5) applyStimulus(3'b001, 4'b0001, 1'b0);
    checkOutput("stall_valid", o_return_valid, 1);
    checkOutput("stall_coin", o_return_coin, 3'b100);
    readyMode = 1;
    drainReturn();

    $display("[TB] ceiling reject and same-cycle coin plus select");
    repeat (9) applyStimulus(3'b100, '0, 1'b0);
    applyStimulus(3'b010, '0, 1'b0);
    applyStimulus(3'b001, '0, 1'b0);
    applyStimulus(3'b100, '0, 1'b0);
    checkOutput("bal_9600_kept", o_balance, 9600);
    readyMode = 0;
    applyStimulus('0, '0, 1'b1);
    drainReturn();
    repeat (4) applyStimulus(3'b001, '0, 1'b0);
    applyStimulus(3'b001, 4'b0001, 1'b0);
    checkOutput("bal_coin_vend", o_balance, 100);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 99);
      c = (r < 25) ? 3'(1 << $urandom_range(0, 2)) : (r < 28) ? 3'($urandom_range(0, 7)) : 3'b000;
      r = $urandom_range(0, 99);
      s = (r < 20) ? 4'(1 << $urandom_range(0, 3)) : (r < 23) ? 4'($urandom_range(0, 15)) : 4'b0000;
      applyStimulus(c, s, $urandom_range(0, 99) < 3);
    end
    drainReturn();

    $display("[TB] sales audit and reset during return");
    doReset();
    readyMode = 1;
    applyStimulus(3'b100, '0, 1'b0);
    applyStimulus(3'b100, '0, 1'b0);
    applyStimulus(3'b010, '0, 1'b0);
    applyStimulus('0, 4'b0001, 1'b0);
    applyStimulus('0, 4'b1000, 1'b0);
    applyStimulus('0, '0, 1'b0);
    applyStimulus('0, '0, 1'b0);
`ifdef VEND_AUDIT_EN
    checkOutput("sales_2400", o_sales_total, 2400);
`endif
    applyStimulus(3'b100, '0, 1'b0);
    readyMode = 2;
    applyStimulus('0, '0, 1'b1);
    repeat (3) applyStimulus('0, '0, 1'b0);
    checkOutput("pre_reset_valid", o_return_valid, 1);
    reset = 1'b1;
    #1;
    checkOutput("async_valid", o_return_valid, 0);
    checkOutput("async_balance", o_balance, 0);
    checkOutput("async_busy", o_busy, 0);
`ifdef VEND_AUDIT_EN
    checkOutput("async_sales", o_sales_total, 0);
`endif
    doReset();
    readyMode = 0;

    checkOutput("vend_queue_empty", vendQ.size(), 0);
    checkOutput("reject_queue_empty", rejectQ.size(), 0);
    checkOutput("coin_queue_empty", coinQ.size(), 0);
    finishRun();
  end

endmodule
